joy_db15_tx: RTL and testbench



---
 rtl/joy_db15_pkg.sv | 18 +
 rtl/joy_db15_tx_sync_edge.sv | 28 ++
 rtl/joy_db15_tx.sv | 91 +++++++++
 tb/tb_joy_db15_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/joy_db15_pkg.sv
// joy_db15_pkg: shared frame constants, button indices and transmitter states
package joy_db15_pkg;
  localparam int BITS_DEFAULT = 12;
  localparam int FRAME_BITS = 2 * BITS_DEFAULT;
  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_A = 4;
  localparam int BTN_B = 5;
  localparam int BTN_C = 6;
  localparam int BTN_D2 = 7;
  localparam int BTN_E = 8;
  localparam int BTN_F = 9;
  localparam int BTN_S = 10;
  localparam int BTN_M = 11;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} tx_state_t;
endpackage

// File: rtl/joy_db15_tx_sync_edge.sv
// sync_edge: multi-flop synchronizer with rising-edge detect, idles high out of reset
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign level = sync_q[STAGES-1];
  assign rise = level & ~prev_q;
endmodule

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: 74HC165-style serial transmitter for two DB15 joystick words
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int BITS_PER_PLAYER = FRAME_BITS / 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [BITS_PER_PLAYER-1:0] joystick1,
  input  logic [BITS_PER_PLAYER-1:0] joystick2,
  input  logic                       joy_load,
  input  logic                       joy_clk,
  output logic                       joy_data,
  output logic                       busy,
  output logic                       frame_done
);
  localparam int FRAME = 2 * BITS_PER_PLAYER;
  localparam int CW = $clog2(FRAME);
  localparam logic [CW-1:0] PENULT = CW'(FRAME - 2);
  tx_state_t state_q, state_d;
  logic [FRAME-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic data_q, data_d, busy_q, busy_d, done_q, done_d;
  logic load_lvl, load_rise, clk_rise, unused_clk_level;
  sync_edge #(.STAGES(SYNC_STAGES)) u_load (
    .clk(clk), .reset_n(reset_n), .din(joy_load), .level(load_lvl), .rise(load_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_clk (
    .clk(clk), .reset_n(reset_n), .din(joy_clk), .level(unused_clk_level), .rise(clk_rise)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d = cnt_q;
    data_d = data_q;
    busy_d = busy_q;
    done_d = 1'b0;
    // load is transparent and outranks any joy_clk edge in the same cycle
    if (!load_lvl) begin
      state_d = LOAD;
      shift_d = {~joystick2, ~joystick1};
      cnt_d = '0;
      data_d = ~joystick1[0];
      busy_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          data_d = 1'b1;
          busy_d = 1'b0;
        end
        LOAD: state_d = load_rise ? SHIFT : LOAD;
        SHIFT: if (clk_rise) begin
          shift_d = {1'b1, shift_q[FRAME-1:1]};
          data_d = shift_q[1];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == PENULT) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            state_d = DONE;
          end
        end
        DONE: if (clk_rise) begin
          shift_d = {1'b1, shift_q[FRAME-1:1]};
          data_d = shift_q[1];
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '1;
      cnt_q <= '0;
      data_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign joy_data = data_q;
  assign busy = busy_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx: directed checks of load, shift, reload, overrun and async reset
module tb_joy_db15_tx;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [11:0] joystick1 = '0;
  logic [11:0] joystick2 = '0;
  logic joy_load = 1'b1;
  logic joy_clk = 1'b1;
  logic joy_data, busy, frame_done;
  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  joy_db15_tx #(.BITS_PER_PLAYER(12), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .joystick1(joystick1), .joystick2(joystick2),
    .joy_load(joy_load), .joy_clk(joy_clk), .joy_data(joy_data), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic clk_pulse();
    joy_clk = 1'b0;
    repeat (4) @(negedge clk);
    joy_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic load_words(input logic [11:0] a, input logic [11:0] b);
    joystick1 = a;
    joystick2 = b;
    joy_load = 1'b0;
    repeat (10) @(negedge clk);
    joy_load = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic read_frame(output logic [23:0] bits, input int chg_at);
    bits[0] = joy_data;
    for (int i = 1; i < 24; i++) begin
      if (i == chg_at) joystick1 = 12'hFFF;
      clk_pulse();
      bits[i] = joy_data;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (joy_data !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: data=%b busy=%b done=%b required 1 0 0", joy_data, busy, frame_done);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      checks++;
      if (joy_data !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: data=%b busy=%b done=%b required 1 0 0", i, joy_data, busy, frame_done);
      end
    end
  endtask

  task automatic test_single_bits();
    logic [23:0] bits;
    int fd0;
    fd0 = fd_cnt;
    load_words(12'h001, 12'h800);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_load: busy=%b required 1", busy);
    end
    bits[0] = joy_data;
    for (int i = 1; i < 23; i++) begin
      clk_pulse();
      bits[i] = joy_data;
    end
    checks++;
    if (fd_cnt !== fd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_pre_last: done_pulses=%0d busy=%b required 0 1", fd_cnt - fd0, busy);
    end
    clk_pulse();
    bits[23] = joy_data;
    checks++;
    if (bits !== 24'h7FFFFE) begin
      errors++;
      $display("FAIL single_bits: got %h required 7ffffe", bits);
    end
    checks++;
    if (fd_cnt - fd0 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done_pulses=%0d busy=%b required 1 0", fd_cnt - fd0, busy);
    end
    clk_pulse();
    checks++;
    if (joy_data !== 1'b1 || fd_cnt - fd0 !== 1) begin
      errors++;
      $display("FAIL single_overrun: data=%b done_pulses=%0d required 1 1", joy_data, fd_cnt - fd0);
    end
  endtask

  task automatic test_pattern();
    logic [23:0] bits;
    int fd0;
    fd0 = fd_cnt;
    load_words(12'hA5A, 12'h35C);
    read_frame(bits, 6);
    checks++;
    if (bits !== 24'hCA35A5) begin
      errors++;
      $display("FAIL pattern_bits: got %h required ca35a5", bits);
    end
    checks++;
    if (fd_cnt - fd0 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pattern_done: done_pulses=%0d busy=%b required 1 0", fd_cnt - fd0, busy);
    end
  endtask

  task automatic test_reload();
    int fd0;
    fd0 = fd_cnt;
    load_words(12'hA5A, 12'h35C);
    repeat (7) clk_pulse();
    checks++;
    if (joy_data !== 1'b1) begin
      errors++;
      $display("FAIL reload_bit7: data=%b required 1", joy_data);
    end
    joystick1 = 12'h001;
    joy_load = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (joy_data !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_latency: data=%b busy=%b required 0 1", joy_data, busy);
    end
    repeat (5) @(negedge clk);
    joy_load = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (fd_cnt !== fd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_state: done_pulses=%0d busy=%b required 0 1", fd_cnt - fd0, busy);
    end
    clk_pulse();
    checks++;
    if (joy_data !== 1'b1) begin
      errors++;
      $display("FAIL reload_bit1: data=%b required 1", joy_data);
    end
  endtask

  task automatic test_coincident();
    joystick1 = 12'h002;
    joystick2 = 12'h000;
    joy_clk = 1'b0;
    repeat (4) @(negedge clk);
    joy_load = 1'b0;
    joy_clk = 1'b1;
    repeat (6) @(negedge clk);
    joy_load = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (joy_data !== 1'b1) begin
      errors++;
      $display("FAIL coinc_bit0: data=%b required 1", joy_data);
    end
    clk_pulse();
    checks++;
    if (joy_data !== 1'b0) begin
      errors++;
      $display("FAIL coinc_bit1: data=%b required 0", joy_data);
    end
    clk_pulse();
    checks++;
    if (joy_data !== 1'b1) begin
      errors++;
      $display("FAIL coinc_bit2: data=%b required 1", joy_data);
    end
  endtask

  task automatic test_async_reset();
    int fd0;
    fd0 = fd_cnt;
    load_words(12'hFFF, 12'hFFF);
    repeat (12) clk_pulse();
    checks++;
    if (joy_data !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_bit12: data=%b busy=%b required 0 1", joy_data, busy);
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (joy_data !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_async: data=%b busy=%b required 1 0", joy_data, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_pulse();
      checks++;
      if (joy_data !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL areset_noload %0d: data=%b busy=%b required 1 0", i, joy_data, busy);
      end
    end
    checks++;
    if (fd_cnt !== fd0) begin
      errors++;
      $display("FAIL areset_done: done_pulses=%0d required 0", fd_cnt - fd0);
    end
  endtask

  initial begin
    test_reset();
    test_single_bits();
    test_pattern();
    test_reload();
    test_coincident();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
